// File: rtl/ram_param_bist_pkg.sv
// ram_param_bist_pkg: shared types and helpers for the parametrised BIST RAM.
//   state_t : controller states (zero-fill, user access, BIST write/read/clear)
//   pat()   : BIST data pattern, address XOR mask (caller casts to DATA_W)
package ram_param_bist_pkg;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,   // post-reset zero-fill sweep
        IDLE  = 3'd1,   // user read/write accepted
        B_WR  = 3'd2,   // BIST pattern write sweep
        B_RD  = 3'd3,   // BIST read/verify sweep (+1 drain cycle)
        B_CLR = 3'd4    // BIST zero-fill sweep
    } state_t;

    // Address zero-extended and XORed with the mask; both arguments arrive
    // zero-extended to 64 bits so any DATA_W/ADDR_W combination works.
    function automatic logic [63:0] pat(input logic [63:0] addr, input logic [63:0] mask);
        return addr ^ mask;
    endfunction

endpackage

// File: rtl/ram_param_bist_if.sv
// ram_param_bist_if: user/BIST bus of the RAM.
//   master : drives i_load, i_address, i_in, i_bist_start; sees all o_* results
//   slave  : the RAM side
interface ram_param_bist_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    logic              i_load;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_in;
    logic              i_bist_start;
    logic [DATA_W-1:0] o_out;
    logic              o_ready;
    logic              o_bist_busy;
    logic              o_bist_done;
    logic              o_test_pass;
    logic [DATA_W-1:0] o_debug_data;
    logic [ADDR_W-1:0] o_fail_addr;

    modport master (
        output i_load, i_address, i_in, i_bist_start,
        input  o_out, o_ready, o_bist_busy, o_bist_done, o_test_pass, o_debug_data, o_fail_addr
    );

    modport slave (
        input  i_load, i_address, i_in, i_bist_start,
        output o_out, o_ready, o_bist_busy, o_bist_done, o_test_pass, o_debug_data, o_fail_addr
    );
endinterface

// File: rtl/ram_param_bist_sp_core.sv
// ram_sp_core: single-port RAM array with one write port and a registered,
// enable-gated, write-first read. Optional stuck-at-1 on bit 0 of one word.
//   clk, srst : clock, synchronous reset of the read register only
//   i_we      : write enable (i_wdata -> mem[i_addr])
//   i_re      : read enable (updates o_rdata)
//   i_addr    : shared read/write address
//   o_rdata   : registered read data
module ram_sp_core #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 14,
    parameter bit STUCK_EN   = 1'b0,
    parameter int STUCK_ADDR = 0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LP_STUCK = ADDR_W'(STUCK_ADDR);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_stuck_mask;

    // Fault mask: only bit 0 of the selected word can be forced high.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_mask
            if (gi == 0 && STUCK_EN) begin : g_stuck
                assign w_stuck_mask[gi] = (i_addr == LP_STUCK);
            end else begin : g_clean
                assign w_stuck_mask[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we ? i_wdata : r_mem[i_addr]) | w_stuck_mask;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_param_bist.sv
// ram_param_bist: parametrised single-port data RAM with post-reset zero-fill
// and a write/verify/clear built-in self-test.
//   clk   : clock, all logic on rising edge
//   reset : synchronous, active-high; restarts the zero-fill sweep
//   bus   : slave side of ram_param_bist_if (user access, BIST control, results)
module ram_param_bist
    import ram_param_bist_pkg::*;
#(
    parameter int          DATA_W     = 16,
    parameter int          ADDR_W     = 14,
    parameter logic [15:0] PATTERN    = 16'hA5C3,
    parameter bit          STUCK_EN   = 1'b0,
    parameter int          STUCK_ADDR = 0
) (
    input  logic               clk,
    input  logic               reset,
    ram_param_bist_if.slave    bus
);
    localparam logic [63:0] LP_MASK = 64'(PATTERN);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_drain;       // extra B_RD cycle that only finishes the compare
    logic              r_cmp_valid;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_mismatch;
    logic              r_busy, r_done, r_pass;
    logic [DATA_W-1:0] r_debug;
    logic [ADDR_W-1:0] r_fail_addr;
    logic              r_from_idle;   // core read register holds a user read
    logic [DATA_W-1:0] r_hold;        // out value frozen while not in IDLE

    logic              w_we, w_re, w_ptr_last;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_wdata, w_rdata, w_out, w_pat_ptr, w_pat_cmp;

    assign w_ptr_last = (r_ptr == '1);
    assign w_pat_ptr  = DATA_W'(pat(64'(r_ptr), LP_MASK));
    assign w_pat_cmp  = DATA_W'(pat(64'(r_cmp_addr), LP_MASK));

    ram_sp_core #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STUCK_EN(STUCK_EN), .STUCK_ADDR(STUCK_ADDR)
    ) u_core (
        .clk(clk), .srst(reset), .i_we(w_we), .i_re(w_re),
        .i_addr(w_mem_addr), .i_wdata(w_wdata), .o_rdata(w_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= CLEAR;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (w_ptr_last)       w_state_next = IDLE;
            IDLE:    if (bus.i_bist_start) w_state_next = B_WR;
            B_WR:    if (w_ptr_last)       w_state_next = B_RD;
            B_RD:    if (r_drain)          w_state_next = B_CLR;
            B_CLR:   if (w_ptr_last)       w_state_next = IDLE;
            default:                       w_state_next = CLEAR;
        endcase
    end

    // Memory port control
    always_comb begin
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_mem_addr = r_ptr;
        w_wdata    = '0;
        case (r_state)
            CLEAR, B_CLR: w_we = 1'b1;
            IDLE: begin
                w_mem_addr = bus.i_address;
                w_wdata    = bus.i_in;
                // A BIST request wins over a same-cycle user write.
                w_we       = bus.i_load & ~bus.i_bist_start;
                w_re       = 1'b1;
            end
            B_WR: begin
                w_we    = 1'b1;
                w_wdata = w_pat_ptr;
            end
            B_RD:    w_re = ~r_drain;
            default: ;
        endcase
    end

    // Sweep pointer, compare pipeline, results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_drain     <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_mismatch  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_debug     <= '0;
            r_fail_addr <= '0;
            r_from_idle <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_from_idle <= (r_state == IDLE);
            r_hold      <= w_out;
            r_cmp_valid <= (r_state == B_RD) && !r_drain;
            r_cmp_addr  <= r_ptr;
            r_drain     <= (r_state == B_RD) && !r_drain && w_ptr_last;

            if (r_state != w_state_next)
                r_ptr <= '0;
            else if (r_state != IDLE)
                r_ptr <= r_ptr + 1'b1;

            if (r_state == IDLE && bus.i_bist_start) begin
                r_busy      <= 1'b1;
                r_pass      <= 1'b0;
                r_debug     <= '0;
                r_fail_addr <= '0;
                r_mismatch  <= 1'b0;
            end

            // Only the first mismatch is recorded.
            if (r_cmp_valid && (w_rdata != w_pat_cmp) && !r_mismatch) begin
                r_mismatch  <= 1'b1;
                r_fail_addr <= r_cmp_addr;
                r_debug     <= w_rdata;
            end

            if (r_state == B_CLR && w_ptr_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= !r_mismatch;
            end
        end
    end

    // User read data is the core register only after an IDLE access;
    // otherwise the last shown value is held.
    assign w_out = r_from_idle ? w_rdata : r_hold;

    assign bus.o_out        = w_out;
    assign bus.o_ready      = (r_state == IDLE);
    assign bus.o_bist_busy  = r_busy;
    assign bus.o_bist_done  = r_done;
    assign bus.o_test_pass  = r_pass;
    assign bus.o_debug_data = r_debug;
    assign bus.o_fail_addr  = r_fail_addr;
endmodule
